// File: rtl/dma_stream_engine.sv
// Streaming DMA engine: moves `size` cache lines from a read channel to a write channel
// through an elastic FIFO, with copy, XOR-transform and fill modes plus a busy-cycle counter.
//
// state   | meaning
// S_IDLE  | waiting for go
// S_START | one-cycle rd_go/wr_go pulse (none when size==0)
// S_RUN   | moving lines until wr_count reaches size
// S_FLUSH | waiting for the write channel to report completion
// S_DONE  | done held high until the next accepted go
module dma_stream_engine #(
  parameter int DATA_WIDTH  = 512,
  parameter int ADDR_WIDTH  = 64,
  parameter int SIZE_WIDTH  = 43,
  parameter int FIFO_DEPTH  = 16,
  parameter int CYCLE_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   go,
  input  logic [1:0]             mode,
  input  logic [ADDR_WIDTH-1:0]  rd_addr_in,
  input  logic [ADDR_WIDTH-1:0]  wr_addr_in,
  input  logic [SIZE_WIDTH-1:0]  size,
  input  logic [DATA_WIDTH-1:0]  key,
  output logic                   busy,
  output logic                   done,
  output logic [CYCLE_WIDTH-1:0] cycles,
  output logic [ADDR_WIDTH-1:0]  dma_rd_addr,
  output logic [SIZE_WIDTH-1:0]  dma_rd_size,
  output logic                   dma_rd_go,
  output logic                   dma_rd_en,
  input  logic [DATA_WIDTH-1:0]  dma_rd_data,
  input  logic                   dma_empty,
  output logic [ADDR_WIDTH-1:0]  dma_wr_addr,
  output logic [SIZE_WIDTH-1:0]  dma_wr_size,
  output logic                   dma_wr_go,
  output logic                   dma_wr_en,
  output logic [DATA_WIDTH-1:0]  dma_wr_data,
  input  logic                   dma_full,
  input  logic                   dma_wr_done
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0]       FULL_CNT = FIFO_DEPTH[PTR_W:0];
  localparam logic [PTR_W:0]       CNT_ONE  = {{PTR_W{1'b0}}, 1'b1};
  localparam logic [PTR_W-1:0]     PTR_ONE  = {{(PTR_W-1){1'b0}}, 1'b1};
  localparam logic [SIZE_WIDTH-1:0]  SIZE_ONE = {{(SIZE_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CYCLE_WIDTH-1:0] CYC_ONE  = {{(CYCLE_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {S_IDLE, S_START, S_RUN, S_FLUSH, S_DONE} state_t;

  state_t                  state;
  logic [1:0]              mode_q;
  logic [DATA_WIDTH-1:0]   key_q;
  logic [SIZE_WIDTH-1:0]   size_q;
  logic [SIZE_WIDTH-1:0]   rd_count;
  logic [SIZE_WIDTH-1:0]   wr_count;
  logic [PTR_W-1:0]        head;
  logic [PTR_W-1:0]        tail;
  logic [PTR_W:0]          fifo_count;
  logic [DATA_WIDTH-1:0]   mem [FIFO_DEPTH];
  logic                    wr_done_seen;

  logic                    fill_mode;
  logic                    in_run;
  logic                    data_avail;
  logic                    push;
  logic                    pop;
  logic                    accept;
  logic [DATA_WIDTH-1:0]   push_data;

  assign fill_mode  = (mode_q == 2'd2);
  assign in_run     = (state == S_RUN);
  assign accept     = go && (state == S_IDLE || state == S_DONE);

  assign dma_rd_en  = in_run && !fill_mode && !dma_empty &&
                      (fifo_count < FULL_CNT) && (rd_count < size_q);

  // In fill mode the key is the data source and rd_count tracks lines generated.
  assign data_avail = fill_mode ? (rd_count < size_q) : (fifo_count != '0);
  assign dma_wr_en  = in_run && data_avail && !dma_full && (wr_count < size_q);
  assign dma_wr_data = fill_mode ? key_q : mem[head];

  assign push       = dma_rd_en;
  assign pop        = dma_wr_en && !fill_mode;
  assign push_data  = (mode_q == 2'd1) ? (dma_rd_data ^ key_q) : dma_rd_data;

  always_ff @(posedge clk) begin
    if (push) mem[tail] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      cycles       <= '0;
      dma_rd_go    <= 1'b0;
      dma_wr_go    <= 1'b0;
      dma_rd_addr  <= '0;
      dma_wr_addr  <= '0;
      dma_rd_size  <= '0;
      dma_wr_size  <= '0;
      mode_q       <= '0;
      key_q        <= '0;
      size_q       <= '0;
      rd_count     <= '0;
      wr_count     <= '0;
      head         <= '0;
      tail         <= '0;
      fifo_count   <= '0;
      wr_done_seen <= 1'b0;
    end else begin
      if (busy && cycles != '1) cycles <= cycles + CYC_ONE;

      if (push) tail <= tail + PTR_ONE;
      if (pop)  head <= head + PTR_ONE;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_ONE;
        2'b01:   fifo_count <= fifo_count - CNT_ONE;
        default: fifo_count <= fifo_count;
      endcase

      if (dma_rd_en || (fill_mode && dma_wr_en)) rd_count <= rd_count + SIZE_ONE;
      if (dma_wr_en) wr_count <= wr_count + SIZE_ONE;

      case (state)
        S_IDLE, S_DONE: begin
          if (accept) begin
            dma_rd_addr  <= rd_addr_in;
            dma_wr_addr  <= wr_addr_in;
            dma_rd_size  <= size;
            dma_wr_size  <= size;
            size_q       <= size;
            mode_q       <= mode;
            key_q        <= key;
            rd_count     <= '0;
            wr_count     <= '0;
            head         <= '0;
            tail         <= '0;
            fifo_count   <= '0;
            cycles       <= '0;
            wr_done_seen <= 1'b0;
            done         <= 1'b0;
            busy         <= 1'b1;
            dma_wr_go    <= (size != '0);
            dma_rd_go    <= (size != '0) && (mode != 2'd2);
            state        <= S_START;
          end
        end
        S_START: begin
          dma_rd_go <= 1'b0;
          dma_wr_go <= 1'b0;
          if (size_q == '0) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            state <= S_RUN;
          end
        end
        S_RUN: begin
          // A completion pulse may arrive with the last write, before FLUSH is reached.
          if (dma_wr_done) wr_done_seen <= 1'b1;
          if (wr_count == size_q) state <= S_FLUSH;
        end
        S_FLUSH: begin
          if (dma_wr_done || wr_done_seen) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dma_stream_engine.sv
// Directed bench for dma_stream_engine with a small read/write channel model and
// hand-computed expectations for copy, XOR, fill, backpressure, size 0 and robustness cases.
module tb_dma_stream_engine;

  localparam int DW = 512;
  localparam int AW = 64;
  localparam int SW = 43;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          go;
  logic [1:0]    mode;
  logic [AW-1:0] rd_addr_in;
  logic [AW-1:0] wr_addr_in;
  logic [SW-1:0] size;
  logic [DW-1:0] key;
  logic          busy;
  logic          done;
  logic [CW-1:0] cycles;
  logic [AW-1:0] dma_rd_addr;
  logic [SW-1:0] dma_rd_size;
  logic          dma_rd_go;
  logic          dma_rd_en;
  logic [DW-1:0] dma_rd_data;
  logic          dma_empty;
  logic [AW-1:0] dma_wr_addr;
  logic [SW-1:0] dma_wr_size;
  logic          dma_wr_go;
  logic          dma_wr_en;
  logic [DW-1:0] dma_wr_data;
  logic          dma_full;
  logic          dma_wr_done;

  dma_stream_engine dut (
    .clk(clk), .rst_n(rst_n), .go(go), .mode(mode),
    .rd_addr_in(rd_addr_in), .wr_addr_in(wr_addr_in), .size(size), .key(key),
    .busy(busy), .done(done), .cycles(cycles),
    .dma_rd_addr(dma_rd_addr), .dma_rd_size(dma_rd_size), .dma_rd_go(dma_rd_go),
    .dma_rd_en(dma_rd_en), .dma_rd_data(dma_rd_data), .dma_empty(dma_empty),
    .dma_wr_addr(dma_wr_addr), .dma_wr_size(dma_wr_size), .dma_wr_go(dma_wr_go),
    .dma_wr_en(dma_wr_en), .dma_wr_data(dma_wr_data), .dma_full(dma_full),
    .dma_wr_done(dma_wr_done)
  );

  always #5 clk = ~clk;

  // Channel model
  logic [DW-1:0] src_mem [64];
  logic [DW-1:0] dst_mem [64];
  int  rd_ptr = 0, rd_lim = 0, wr_ptr = 0, wr_lim = 0;
  logic wr_done_r = 1'b0;
  logic rd_stall = 1'b0, wr_stall = 1'b0;
  logic stall_en, hold_full;
  int  n_rd_go = 0, n_wr_go = 0, n_rd_en = 0, n_wr_en = 0, n_viol = 0;

  assign dma_empty   = rd_stall || (rd_ptr >= rd_lim);
  assign dma_rd_data = (rd_ptr < 64) ? src_mem[rd_ptr] : '0;
  assign dma_full    = wr_stall || hold_full;
  assign dma_wr_done = wr_done_r;

  always @(negedge clk) begin
    rd_stall = stall_en && ($urandom_range(0, 3) == 0);
    wr_stall = stall_en && ($urandom_range(0, 3) == 0);
  end

  always @(posedge clk) begin
    if (dma_rd_go) n_rd_go <= n_rd_go + 1;
    if (dma_wr_go) n_wr_go <= n_wr_go + 1;
    if (dma_rd_en) n_rd_en <= n_rd_en + 1;
    if (dma_wr_en) n_wr_en <= n_wr_en + 1;
    if ((dma_rd_en && dma_empty) || (dma_wr_en && dma_full)) n_viol <= n_viol + 1;
    if (dma_rd_go) begin
      rd_ptr <= 0;
      rd_lim <= int'(dma_rd_size);
    end else if (dma_rd_en) begin
      rd_ptr <= rd_ptr + 1;
    end
    if (dma_wr_go) begin
      wr_ptr    <= 0;
      wr_lim    <= int'(dma_wr_size);
      wr_done_r <= 1'b0;
    end else if (dma_wr_en) begin
      if (wr_ptr < 64) dst_mem[wr_ptr] <= dma_wr_data;
      wr_ptr <= wr_ptr + 1;
      if (wr_ptr + 1 >= wr_lim) wr_done_r <= 1'b1;
    end
  end

  int checks = 0;
  int failures = 0;
  int b_rd_go, b_wr_go, b_rd_en, b_wr_en;

  task automatic chk_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] pat(input int seed, input int i);
    logic [DW-1:0] v;
    for (int w = 0; w < DW / 32; w++)
      v[w*32 +: 32] = 32'(seed * 100003 + i * 977 + w * 31) ^ 32'h5a5a_0000;
    return v;
  endfunction

  task automatic load_src(input int seed);
    for (int i = 0; i < 64; i++) src_mem[i] = pat(seed, i);
  endtask

  task automatic snap();
    b_rd_go = n_rd_go; b_wr_go = n_wr_go; b_rd_en = n_rd_en; b_wr_en = n_wr_en;
  endtask

  task automatic start_xfer(input logic [1:0] m, input int n, input logic [DW-1:0] k);
    @(negedge clk);
    mode = m; size = SW'(n); key = k;
    rd_addr_in = 64'h1000_0000 + 64'(n); wr_addr_in = 64'h2000_0000 + 64'(n);
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int t = 0;
    while (!done && t < budget) begin
      @(negedge clk);
      t++;
    end
    chk_val(tag, 64'(done), 64'd1);
  endtask

  task automatic verify(input string tag, input int n, input logic [1:0] m, input logic [DW-1:0] k);
    int bad = 0;
    logic [DW-1:0] e;
    for (int i = 0; i < n; i++) begin
      e = (m == 2'd2) ? k : (m == 2'd1) ? (src_mem[i] ^ k) : src_mem[i];
      if (dst_mem[i] !== e) bad++;
    end
    chk_val(tag, 64'(bad), 64'd0);
  endtask

  initial begin
    logic [DW-1:0] k_xor;
    logic [DW-1:0] k_fill;
    int t, hold_base;
    k_xor  = {64{8'hA5}};
    k_fill = 512'h1234;
    rst_n = 1'b0; go = 1'b0; mode = 2'd0; size = '0; key = '0;
    rd_addr_in = '0; wr_addr_in = '0; stall_en = 1'b0; hold_full = 1'b0;
    repeat (3) @(negedge clk);
    chk_val("rst_busy", 64'(busy), 64'd0);
    chk_val("rst_done", 64'(done), 64'd0);
    chk_val("rst_cycles", 64'(cycles), 64'd0);
    chk_val("rst_go_en", 64'({dma_rd_go, dma_wr_go, dma_rd_en, dma_wr_en}), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Copy, 64 lines, random stalls on both channels
    load_src(1); stall_en = 1'b1; snap();
    start_xfer(2'd0, 64, '0);
    chk_val("copy_busy", 64'(busy), 64'd1);
    chk_val("copy_rd_addr", dma_rd_addr, 64'h1000_0040);
    chk_val("copy_wr_size", 64'(dma_wr_size), 64'd64);
    wait_done("copy_done", 3000);
    verify("copy_data", 64, 2'd0, '0);
    chk_val("copy_rd_en_n", 64'(n_rd_en - b_rd_en), 64'd64);
    chk_val("copy_wr_en_n", 64'(n_wr_en - b_wr_en), 64'd64);
    chk_val("copy_cyc_gt64", 64'(cycles > 64), 64'd1);
    chk_val("copy_busy_end", 64'(busy), 64'd0);
    stall_en = 1'b0;

    // XOR, 8 lines
    load_src(2); snap();
    start_xfer(2'd1, 8, k_xor);
    wait_done("xor_done", 500);
    verify("xor_data", 8, 2'd1, k_xor);
    chk_val("xor_wr_en_n", 64'(n_wr_en - b_wr_en), 64'd8);

    // Fill, 5 lines, no read activity
    load_src(3); snap();
    start_xfer(2'd2, 5, k_fill);
    wait_done("fill_done", 500);
    verify("fill_data", 5, 2'd2, k_fill);
    chk_val("fill_rd_go_n", 64'(n_rd_go - b_rd_go), 64'd0);
    chk_val("fill_rd_en_n", 64'(n_rd_en - b_rd_en), 64'd0);
    chk_val("fill_wr_en_n", 64'(n_wr_en - b_wr_en), 64'd5);

    // Backpressure: hold the write channel full for 100 cycles mid-transfer
    load_src(4); snap();
    start_xfer(2'd0, 40, '0);
    t = 0;
    while (n_wr_en - b_wr_en < 4 && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk_val("bp_started", 64'(t < 200), 64'd1);
    hold_full = 1'b1;
    hold_base = n_wr_en;
    repeat (100) @(negedge clk);
    chk_val("bp_fifo_full", 64'(dut.fifo_count), 64'd16);
    chk_val("bp_rd_en_low", 64'(dma_rd_en), 64'd0);
    chk_val("bp_no_writes", 64'(n_wr_en - hold_base), 64'd0);
    hold_full = 1'b0;
    wait_done("bp_done", 1000);
    verify("bp_data", 40, 2'd0, '0);
    chk_val("bp_rd_en_n", 64'(n_rd_en - b_rd_en), 64'd40);
    chk_val("bp_wr_en_n", 64'(n_wr_en - b_wr_en), 64'd40);

    // size == 0: done two cycles after go, no channel activity
    snap();
    start_xfer(2'd0, 0, '0);
    chk_val("zero_done_early", 64'(done), 64'd0);
    @(negedge clk);
    chk_val("zero_done", 64'(done), 64'd1);
    chk_val("zero_cyc_le2", 64'(cycles <= 2), 64'd1);
    chk_val("zero_pulses", 64'((n_rd_go - b_rd_go) + (n_wr_go - b_wr_go) +
                               (n_rd_en - b_rd_en) + (n_wr_en - b_wr_en)), 64'd0);

    // go while running is ignored
    load_src(5); stall_en = 1'b1; snap();
    start_xfer(2'd0, 32, '0);
    repeat (5) @(negedge clk);
    size = SW'(7); mode = 2'd2; go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    chk_val("busy_go_size", 64'(dma_rd_size), 64'd32);
    wait_done("busy_go_done", 2000);
    verify("busy_go_data", 32, 2'd0, '0);
    chk_val("busy_go_wr_n", 64'(n_wr_en - b_wr_en), 64'd32);
    stall_en = 1'b0;

    // Reset mid-transfer, then a clean reserved-mode (copy) transfer
    load_src(6);
    start_xfer(2'd0, 32, '0);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_val("mid_rst_busy", 64'(busy), 64'd0);
    chk_val("mid_rst_done", 64'(done), 64'd0);
    chk_val("mid_rst_fifo", 64'(dut.fifo_count), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    load_src(7); snap();
    start_xfer(2'd3, 16, k_xor);
    wait_done("post_rst_done", 500);
    verify("post_rst_data", 16, 2'd3, k_xor);
    chk_val("post_rst_wr_n", 64'(n_wr_en - b_wr_en), 64'd16);
    chk_val("proto_viol", 64'(n_viol), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
